// File: rtl/serial_tx_if.sv
// Parallel-in / serial-out handshake bundle for serial_tx.
// The master drives the word and load; the slave (transmitter) returns status and the line.
interface serial_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] d;
  logic                 load;
  logic                 ready;
  logic                 txd;
  logic                 done;

  modport master (output d, load, input ready, txd, done);
  modport slave  (input d, load, output ready, txd, done);
endinterface

// File: rtl/serial_tx.sv
// Asynchronous serial transmitter: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit.
// Each bit lasts CLKS_PER_BIT clocks; txd comes straight from a flop so the pin never glitches.
//
// state | meaning
// IDLE  | line high, ready for a load
// START | start bit (txd=0) for one bit time
// DATA  | shifting data bits out, LSB first
// STOP  | stop bit (txd=1); done in its last cycle
module serial_tx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input logic        clk,
  input logic        clrn,
  serial_tx_if.slave bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   txd_q, txd_d;
  logic                   baud_end;

  assign baud_end = (baud_q == BAUD_MAX);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (bus.load) begin
          shift_d = bus.d;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (baud_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The line level is registered from the upcoming state so it lines up with it.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  assign bus.txd   = txd_q;
  assign bus.ready = (state_q == IDLE);
  assign bus.done  = (state_q == STOP) && baud_end;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: an 8-bit/4-clock instance and a 5-bit/2-clock instance,
// each compared cycle by cycle against a frame model computed from the frame format.
module tb_serial_tx;

  logic clk = 1'b0;
  logic clrn;
  int   checks   = 0;
  int   failures = 0;

  serial_tx_if #(.DATA_BITS(8)) ifa ();
  serial_tx_if #(.DATA_BITS(5)) ifb ();

  serial_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4)) u_a (.clk(clk), .clrn(clrn), .bus(ifa.slave));
  serial_tx #(.DATA_BITS(5), .CLKS_PER_BIT(2)) u_b (.clk(clk), .clrn(clrn), .bus(ifb.slave));

  always #5 clk = ~clk;

  task automatic drive(input int which, input logic ld, input logic [7:0] w);
    if (which == 0) begin
      ifa.load = ld;
      ifa.d    = w;
    end else begin
      ifb.load = ld;
      ifb.d    = w[4:0];
    end
  endtask

  task automatic sample(input int which, output logic t, output logic r, output logic dn);
    if (which == 0) begin
      t = ifa.txd; r = ifa.ready; dn = ifa.done;
    end else begin
      t = ifb.txd; r = ifb.ready; dn = ifb.done;
    end
  endtask

  // Expected line level at cycle i (0 = first start-bit cycle) of a frame carrying w.
  function automatic logic exp_txd(input logic [7:0] w, input int dbits, input int cpb, input int i);
    int slot;
    slot = i / cpb;
    if (slot == 0) return 1'b0;
    if (slot <= dbits) return w[slot-1];
    return 1'b1;
  endfunction

  task automatic start_load(input int which, input logic [7:0] w);
    drive(which, 1'b1, w);
    @(negedge clk);
  endtask

  // Entered at the negedge of the first frame cycle (load accepted on the previous edge).
  // mode 0: load low; mode 1: busy pokes of 3C at cycles 5 and 20; mode 2: load held with hold_d.
  // Returns at the negedge of the cycle after done, having checked it is the ready cycle.
  task automatic check_frame(input int which, input logic [7:0] w, input int dbits, input int cpb,
                             input int mode, input logic [7:0] hold_d, input string name);
    int   total;
    int   dones;
    logic t, r, dn;
    total = (dbits + 2) * cpb;
    dones = 0;
    for (int i = 0; i < total; i++) begin
      sample(which, t, r, dn);
      checks += 3;
      if (t !== exp_txd(w, dbits, cpb, i)) begin
        failures++;
        $display("FAIL %s txd cycle %0d: got %b expected %b", name, i + 1, t, exp_txd(w, dbits, cpb, i));
      end
      if (dn !== (i == total - 1)) begin
        failures++;
        $display("FAIL %s done cycle %0d: got %b expected %b", name, i + 1, dn, (i == total - 1));
      end
      if (r !== 1'b0) begin
        failures++;
        $display("FAIL %s ready cycle %0d: got %b expected 0", name, i + 1, r);
      end
      if (dn === 1'b1) dones++;
      case (mode)
        1: begin
          if (i == 4 || i == 19) drive(which, 1'b1, 8'h3C);
          else drive(which, 1'b0, 8'($urandom));
        end
        2: drive(which, 1'b1, hold_d);
        default: drive(which, 1'b0, 8'($urandom));
      endcase
      @(negedge clk);
    end
    sample(which, t, r, dn);
    checks += 2;
    if (r !== 1'b1 || dn !== 1'b0 || t !== 1'b1) begin
      failures++;
      $display("FAIL %s after-done: got ready=%b done=%b txd=%b expected ready=1 done=0 txd=1", name, r, dn, t);
    end
    if (dones != 1) begin
      failures++;
      $display("FAIL %s done count: got %0d expected 1", name, dones);
    end
  endtask

  task automatic test_reset();
    logic t, r, dn;
    clrn = 1'b0;
    drive(0, 1'b1, 8'hFF);
    drive(1, 1'b1, 8'hFF);
    repeat (4) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        sample(k, t, r, dn);
        checks++;
        if (t !== 1'b1 || r !== 1'b1 || dn !== 1'b0) begin
          failures++;
          $display("FAIL reset dut%0d: got txd=%b ready=%b done=%b expected 1 1 0", k, t, r, dn);
        end
      end
    end
    drive(0, 1'b0, 8'hFF);
    drive(1, 1'b0, 8'hFF);
    clrn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        sample(k, t, r, dn);
        checks++;
        if (t !== 1'b1 || r !== 1'b1 || dn !== 1'b0) begin
          failures++;
          $display("FAIL post-reset idle dut%0d: got txd=%b ready=%b done=%b expected 1 1 0", k, t, r, dn);
        end
      end
    end
  endtask

  task automatic test_single_frame();
    start_load(0, 8'hA5);
    check_frame(0, 8'hA5, 8, 4, 0, 8'h00, "single_A5");
  endtask

  task automatic test_busy_ignore();
    logic t, r, dn;
    start_load(0, 8'hA5);
    check_frame(0, 8'hA5, 8, 4, 1, 8'h00, "busy_ignore");
    repeat (3) begin
      @(negedge clk);
      sample(0, t, r, dn);
      checks++;
      if (t !== 1'b1 || r !== 1'b1) begin
        failures++;
        $display("FAIL busy_ignore no-second-frame: got txd=%b ready=%b expected 1 1", t, r);
      end
    end
  endtask

  task automatic test_back_to_back();
    start_load(0, 8'h00);
    check_frame(0, 8'h00, 8, 4, 2, 8'hFF, "b2b_frame1");
    @(negedge clk);
    check_frame(0, 8'hFF, 8, 4, 0, 8'h00, "b2b_frame2");
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic t, r, dn;
    start_load(0, 8'h55);
    drive(0, 1'b0, 8'h55);
    repeat (17) @(negedge clk);
    sample(0, t, r, dn);
    checks++;
    if (t !== 1'b0) begin
      failures++;
      $display("FAIL midreset data bit3: got %b expected 0", t);
    end
    #2 clrn = 1'b0;
    #1;
    sample(0, t, r, dn);
    checks++;
    if (t !== 1'b1 || r !== 1'b1 || dn !== 1'b0) begin
      failures++;
      $display("FAIL midreset async: got txd=%b ready=%b done=%b expected 1 1 0", t, r, dn);
    end
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    start_load(0, 8'h81);
    check_frame(0, 8'h81, 8, 4, 0, 8'h00, "after_midreset_81");
  endtask

  task automatic test_param_sweep();
    start_load(1, 8'h13);
    check_frame(1, 8'h13, 5, 2, 0, 8'h00, "sweep_10011");
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] w;
    int mode;
    for (int k = 0; k < 8; k++) begin
      w    = 8'($urandom);
      mode = $urandom_range(0, 1);
      start_load(0, w);
      check_frame(0, w, 8, 4, mode, 8'h00, "random_a");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    for (int k = 0; k < 6; k++) begin
      w = 8'($urandom_range(0, 31));
      start_load(1, w);
      check_frame(1, w, 5, 2, 0, 8'h00, "random_b");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    test_reset();
    test_single_frame();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_frame();
    test_param_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
